// File: rtl/logical_issue_seq.sv
// Issue sequencer for the logical unit: buffers instructions, issues them one at a time,
// and returns tagged results. Define LOGICAL_ISSUE_PERF_EN to add perf counter outputs.
module logical_issue_seq #(
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned TAG_W       = 4,
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     instr_vld_i,
    output logic                     instr_rdy_o,
    input  logic [3:0]               instr_op_i,
    input  logic                     instr_prec_i,
    input  logic                     instr_dir_i,
    input  logic [31:0]              instr_src0_i,
    input  logic [31:0]              instr_src1_i,
    input  logic [2:0]               instr_status_i,
    input  logic [TAG_W-1:0]         instr_tag_i,
    output logic                     logical_vld_o,
    output logic [3:0]               logical_op_o,
    output logic                     logical_precision_o,
    output logic                     shift_dir_o,
    output logic [31:0]              logical_src0_o,
    output logic [31:0]              logical_src1_o,
    output logic [2:0]               fpadd_status_o,
    input  logic                     logical_done_i,
    input  logic [31:0]              logical_dst_i,
    output logic                     resp_vld_o,
    input  logic                     resp_rdy_i,
    output logic [TAG_W-1:0]         resp_tag_o,
    output logic [31:0]              resp_data_o,
    output logic [1:0]               resp_err_o,
    output logic                     busy_o,
`ifdef LOGICAL_ISSUE_PERF_EN
    output logic [31:0]              perf_issue_cnt_o,
    output logic [31:0]              perf_err_cnt_o,
`endif
    output logic [$clog2(DEPTH):0]   fifo_cnt_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned TW = $clog2(TIMEOUT_CYC);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);

    typedef struct packed {
        logic [3:0]       op;
        logic             prec;
        logic             dir;
        logic [31:0]      src0;
        logic [31:0]      src1;
        logic [2:0]       status;
        logic [TAG_W-1:0] tag;
    } entry_t;

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_t;

    entry_t          mem_q [DEPTH];
    entry_t          head;
    entry_t          new_entry;
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   cnt_q;
    logic [TW-1:0]   to_cnt_q;
    state_t          state_q;
    logic            push, pop;

    assign new_entry = '{op: instr_op_i, prec: instr_prec_i, dir: instr_dir_i,
                         src0: instr_src0_i, src1: instr_src1_i,
                         status: instr_status_i, tag: instr_tag_i};
    assign head        = mem_q[rd_ptr_q];
    assign instr_rdy_o = (cnt_q != CW'(DEPTH));
    assign push        = instr_vld_i && instr_rdy_o;
    assign pop         = (state_q == StIdle) && (cnt_q != '0);
    assign fifo_cnt_o  = cnt_q;
    assign busy_o      = (state_q != StIdle) || (cnt_q != '0);

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= new_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + CW'(1);
                2'b01:   cnt_q <= cnt_q - CW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q             <= StIdle;
            to_cnt_q            <= '0;
            logical_vld_o       <= 1'b0;
            logical_op_o        <= '0;
            logical_precision_o <= 1'b0;
            shift_dir_o         <= 1'b0;
            logical_src0_o      <= '0;
            logical_src1_o      <= '0;
            fpadd_status_o      <= '0;
            resp_vld_o          <= 1'b0;
            resp_tag_o          <= '0;
            resp_data_o         <= '0;
            resp_err_o          <= 2'b00;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (pop) begin
                        logical_op_o        <= head.op;
                        logical_precision_o <= head.prec;
                        shift_dir_o         <= head.dir;
                        logical_src0_o      <= head.src0;
                        logical_src1_o      <= head.src1;
                        fpadd_status_o      <= head.status;
                        resp_tag_o          <= head.tag;
                        if (head.op <= 4'd10) begin
                            logical_vld_o <= 1'b1;
                            state_q       <= StIssue;
                        end else begin
                            // Illegal opcode never reaches the unit.
                            resp_vld_o  <= 1'b1;
                            resp_data_o <= '0;
                            resp_err_o  <= 2'b01;
                            state_q     <= StResp;
                        end
                    end
                end
                StIssue: begin
                    logical_vld_o <= 1'b0;
                    to_cnt_q      <= '0;
                    state_q       <= StWait;
                end
                StWait: begin
                    if (logical_done_i) begin
                        resp_vld_o  <= 1'b1;
                        resp_data_o <= logical_dst_i;
                        resp_err_o  <= 2'b00;
                        state_q     <= StResp;
                    end else if (to_cnt_q == TO_LAST) begin
                        resp_vld_o  <= 1'b1;
                        resp_data_o <= '0;
                        resp_err_o  <= 2'b10;
                        state_q     <= StResp;
                    end else begin
                        to_cnt_q <= to_cnt_q + TW'(1);
                    end
                end
                StResp: begin
                    if (resp_rdy_i) begin
                        resp_vld_o <= 1'b0;
                        state_q    <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

`ifdef LOGICAL_ISSUE_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_issue_cnt_o <= '0;
            perf_err_cnt_o   <= '0;
        end else begin
            if (logical_vld_o && (perf_issue_cnt_o != 32'hFFFF_FFFF)) begin
                perf_issue_cnt_o <= perf_issue_cnt_o + 32'd1;
            end
            if (resp_vld_o && resp_rdy_i && (resp_err_o != 2'b00) &&
                (perf_err_cnt_o != 32'hFFFF_FFFF)) begin
                perf_err_cnt_o <= perf_err_cnt_o + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_logical_issue_seq.sv
// Directed bench for logical_issue_seq with a behavioural logical-unit model of
// configurable done latency (0 = never done).
module tb_logical_issue_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        instr_vld = 1'b0;
    logic        instr_rdy;
    logic [3:0]  instr_op = '0;
    logic        instr_prec = 1'b0;
    logic        instr_dir = 1'b0;
    logic [31:0] instr_src0 = '0;
    logic [31:0] instr_src1 = '0;
    logic [2:0]  instr_status = '0;
    logic [3:0]  instr_tag = '0;
    logic        logical_vld;
    logic [3:0]  logical_op;
    logic        logical_precision;
    logic        shift_dir;
    logic [31:0] logical_src0;
    logic [31:0] logical_src1;
    logic [2:0]  fpadd_status;
    logic        logical_done;
    logic [31:0] logical_dst = '0;
    logic        resp_vld;
    logic        resp_rdy = 1'b1;
    logic [3:0]  resp_tag;
    logic [31:0] resp_data;
    logic [1:0]  resp_err;
    logic        busy;
    logic [2:0]  fifo_cnt;
`ifdef LOGICAL_ISSUE_PERF_EN
    logic [31:0] perf_issue_cnt;
    logic [31:0] perf_err_cnt;
`endif

    int total = 0;
    int bad = 0;
    int model_lat = 1;
    int cd = 0;
    int pulses = 0;
    logic force_done = 1'b0;

    always #5 clk = ~clk;

    logical_issue_seq #(.DEPTH(4), .TAG_W(4), .TIMEOUT_CYC(16)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .instr_vld_i         (instr_vld),
        .instr_rdy_o         (instr_rdy),
        .instr_op_i          (instr_op),
        .instr_prec_i        (instr_prec),
        .instr_dir_i         (instr_dir),
        .instr_src0_i        (instr_src0),
        .instr_src1_i        (instr_src1),
        .instr_status_i      (instr_status),
        .instr_tag_i         (instr_tag),
        .logical_vld_o       (logical_vld),
        .logical_op_o        (logical_op),
        .logical_precision_o (logical_precision),
        .shift_dir_o         (shift_dir),
        .logical_src0_o      (logical_src0),
        .logical_src1_o      (logical_src1),
        .fpadd_status_o      (fpadd_status),
        .logical_done_i      (logical_done),
        .logical_dst_i       (logical_dst),
        .resp_vld_o          (resp_vld),
        .resp_rdy_i          (resp_rdy),
        .resp_tag_o          (resp_tag),
        .resp_data_o         (resp_data),
        .resp_err_o          (resp_err),
        .busy_o              (busy),
`ifdef LOGICAL_ISSUE_PERF_EN
        .perf_issue_cnt_o    (perf_issue_cnt),
        .perf_err_cnt_o      (perf_err_cnt),
`endif
        .fifo_cnt_o          (fifo_cnt)
    );

    function automatic logic [31:0] lu_f(input logic [3:0] op, input logic prec,
                                         input logic dir, input logic [31:0] a,
                                         input logic [31:0] b);
        logic [31:0] r;
        logic [15:0] h;
        int s;
        r = '0;
        h = a[15:0];
        case (op)
            4'd0:  r = a & b;
            4'd1:  r = a | b;
            4'd2:  r = a ^ b;
            4'd3:  r = ~a;
            4'd4:  r = a;
            4'd10: begin
                if (prec) begin
                    s = int'(b[4:0]);
                    r = dir ? ((a >> s) | (a << (32 - s))) : ((a << s) | (a >> (32 - s)));
                end else begin
                    s = int'(b[3:0]);
                    r = {16'h0, dir ? ((h >> s) | (h << (16 - s)))
                                    : ((h << s) | (h >> (16 - s)))};
                end
            end
            default: r = '0;
        endcase
        return r;
    endfunction

    // Logical-unit model: done pulses model_lat cycles after the issue strobe.
    assign logical_done = (cd == 1) || force_done;

    always @(posedge clk) begin
        if (logical_vld) begin
            cd          <= model_lat;
            logical_dst <= lu_f(logical_op, logical_precision, shift_dir,
                                logical_src0, logical_src1);
            pulses      <= pulses + 1;
        end else if (cd != 0) begin
            cd <= cd - 1;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [3:0] op, input logic prec, input logic dir,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] st, input logic [3:0] tag);
        instr_op     = op;
        instr_prec   = prec;
        instr_dir    = dir;
        instr_src0   = a;
        instr_src1   = b;
        instr_status = st;
        instr_tag    = tag;
        instr_vld    = 1'b1;
        tick();
        instr_vld    = 1'b0;
    endtask

    task automatic wait_resp(output int cyc);
        cyc = 0;
        while (!resp_vld && cyc < 100) begin
            tick();
            cyc++;
        end
        check("resp_seen", {31'h0, resp_vld}, 32'd1);
    endtask

    initial begin
        int cyc;
        int p0;
        int exp_tag;
        logic seen;

        // Reset state
        @(negedge clk);
        tick();
        rst = 1'b0;
        check("rst_rdy", {31'h0, instr_rdy}, 32'd1);
        check("rst_resp_vld", {31'h0, resp_vld}, 32'd0);
        check("rst_lvld", {31'h0, logical_vld}, 32'd0);
        check("rst_busy", {31'h0, busy}, 32'd0);
        check("rst_cnt", {29'h0, fifo_cnt}, 32'd0);
        check("rst_data", resp_data, 32'd0);

        // Basic AND with nominal latency
        push(4'd0, 1'b1, 1'b0, 32'hF0F0_1234, 32'h0FF0_FFFF, 3'b000, 4'd3);
        check("and_cnt", {29'h0, fifo_cnt}, 32'd1);
        check("and_busy", {31'h0, busy}, 32'd1);
        tick();
        check("and_issue_vld", {31'h0, logical_vld}, 32'd1);
        check("and_issue_src0", logical_src0, 32'hF0F0_1234);
        tick();
        check("and_wait_vld", {31'h0, logical_vld}, 32'd0);
        check("and_wait_resp", {31'h0, resp_vld}, 32'd0);
        tick();
        check("and_resp_vld", {31'h0, resp_vld}, 32'd1);
        check("and_data", resp_data, 32'h00F0_1234);
        check("and_tag", {28'h0, resp_tag}, 32'd3);
        check("and_err", {30'h0, resp_err}, 32'd0);
        tick();
        check("and_resp_drop", {31'h0, resp_vld}, 32'd0);
        check("and_pulses", pulses, 32'd1);

        // FIFO full under back-pressure, then drain in order
        resp_rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            push(4'd1, 1'b1, 1'b0, 32'(i), 32'h100, 3'b000, 4'(i));
        end
        check("full_cnt", {29'h0, fifo_cnt}, 32'd4);
        check("full_rdy", {31'h0, instr_rdy}, 32'd0);
        check("full_resp_tag0", {28'h0, resp_tag}, 32'd0);
        tick();
        tick();
        tick();
        check("full_hold_vld", {31'h0, resp_vld}, 32'd1);
        check("full_hold_tag", {28'h0, resp_tag}, 32'd0);
        check("full_hold_data", resp_data, 32'h100);
        resp_rdy = 1'b1;
        exp_tag = 0;
        for (int c = 0; c < 80 && exp_tag < 5; c++) begin
            if (resp_vld) begin
                check("drain_tag", {28'h0, resp_tag}, 32'(exp_tag));
                check("drain_data", resp_data, 32'h100 | 32'(exp_tag));
                check("drain_err", {30'h0, resp_err}, 32'd0);
                exp_tag++;
            end
            tick();
        end
        check("drain_count", exp_tag, 32'd5);
        check("drain_empty", {29'h0, fifo_cnt}, 32'd0);

        // Illegal opcode, then a legal one
        p0 = pulses;
        push(4'hC, 1'b1, 1'b0, 32'h1234_5678, 32'h1, 3'b000, 4'd7);
        wait_resp(cyc);
        check("ill_tag", {28'h0, resp_tag}, 32'd7);
        check("ill_err", {30'h0, resp_err}, 32'd1);
        check("ill_data", resp_data, 32'd0);
        tick();
        check("ill_no_issue", pulses, 32'(p0));
        push(4'd2, 1'b1, 1'b0, 32'hFFFF_0000, 32'h0F0F_0F0F, 3'b000, 4'd8);
        wait_resp(cyc);
        check("xor_latency", cyc, 32'd3);
        check("xor_data", resp_data, 32'hF0F0_0F0F);
        check("xor_tag", {28'h0, resp_tag}, 32'd8);
        tick();
        check("xor_issued", pulses, 32'(p0 + 1));
`ifdef LOGICAL_ISSUE_PERF_EN
        check("perf_issue", perf_issue_cnt, 32'd7);
        check("perf_err", perf_err_cnt, 32'd1);
`endif

        // Timeout, then a spurious done in IDLE
        model_lat = 0;
        push(4'd0, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b000, 4'd9);
        wait_resp(cyc);
        check("to_latency", cyc, 32'd18);
        check("to_err", {30'h0, resp_err}, 32'd2);
        check("to_data", resp_data, 32'd0);
        check("to_tag", {28'h0, resp_tag}, 32'd9);
        tick();
        force_done = 1'b1;
        tick();
        force_done = 1'b0;
        tick();
        check("spur_resp", {31'h0, resp_vld}, 32'd0);
        check("spur_busy", {31'h0, busy}, 32'd0);

        // Operand stability across a 5-cycle WAIT
        model_lat = 5;
        push(4'd10, 1'b0, 1'b1, 32'h0000_8001, 32'd1, 3'b010, 4'd5);
        tick();
        check("rot_issue", {31'h0, logical_vld}, 32'd1);
        tick();
        for (int i = 0; i < 5; i++) begin
            check("rot_stable", {logical_vld, logical_op, logical_precision, shift_dir,
                                 fpadd_status, logical_src0[15:0], 6'h0},
                  {1'b0, 4'd10, 1'b0, 1'b1, 3'b010, 16'h8001, 6'h0});
            check("rot_src1", logical_src1, 32'd1);
            tick();
        end
        check("rot_resp_vld", {31'h0, resp_vld}, 32'd1);
        check("rot_data", resp_data, 32'h0000_C000);
        tick();

        // Reset mid-WAIT with two entries queued
        model_lat = 8;
        push(4'd0, 1'b1, 1'b0, 32'hA, 32'hF, 3'b000, 4'd1);
        push(4'd0, 1'b1, 1'b0, 32'hB, 32'hF, 3'b000, 4'd2);
        push(4'd0, 1'b1, 1'b0, 32'hC, 32'hF, 3'b000, 4'd3);
        check("mid_cnt", {29'h0, fifo_cnt}, 32'd2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_cnt", {29'h0, fifo_cnt}, 32'd0);
        check("mid_rst_resp", {31'h0, resp_vld}, 32'd0);
        check("mid_rst_busy", {31'h0, busy}, 32'd0);
        check("mid_rst_lvld", {31'h0, logical_vld}, 32'd0);
`ifdef LOGICAL_ISSUE_PERF_EN
        check("mid_perf_issue", perf_issue_cnt, 32'd0);
        check("mid_perf_err", perf_err_cnt, 32'd0);
`endif
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            seen = seen | resp_vld | logical_vld | busy;
            tick();
        end
        check("late_done_ignored", {31'h0, seen}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
